press_waveform_gen: RTL and testbench
=====================================

Name: press_waveform_gen

Overview:
- Transmit side of the S2 button interface: turns a requested press event (short or long) into a debounced-level button waveform (`btn_out`).
- `btn_out` drives the press detector's `btn_in` in self-test/demo mode, muxed ahead of the real debounced key.
- Runs on the 100 Hz debounce clock; one tick = 10 ms.
- Each request yields one high pulse of SHORT_TICKS or LONG_TICKS, then a mandatory low gap.

Parameters:
- SHORT_TICKS, 10, high time for a short press in clk_db ticks; legal range 1..99.
- LONG_TICKS, 150, high time for a long press; legal range 102..255 (detector threshold 100 plus edge latency).
- GAP_TICKS, 5, low time after release before the next request is accepted; legal range 1..255.

Ports:
- clk_db  input  1  100 Hz debounce clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_long  input  1  request type: 1 = long, 0 = short; sampled only at handshake.
- req_ready  output  1  generator can accept a request.
- btn_out  output  1  generated button level, active high.
- busy  output  1  waveform in progress (PRESS or GAP).
- done  output  1  one-cycle pulse when the gap completes.

Behaviour:
- Reset: all registers asynchronously cleared on rst_n=0.
  - btn_out=0, busy=0, done=0, req_ready=1 once reset is released.
  - state=IDLE, tick counter=0, latched type=0.
- FSM states: IDLE, PRESS, GAP.
- IDLE:
  - req_ready=1.
  - Handshake is req_valid && req_ready at a rising edge.
  - On handshake: latch req_long, counter<=0, go to PRESS.
  - btn_out rises on the same edge (registered), i.e. 1 cycle after the handshake cycle.
- PRESS:
  - btn_out=1, busy=1, req_ready=0.
  - Counter increments each tick.
  - When counter == HOLD-1 (HOLD = LONG_TICKS if latched long, else SHORT_TICKS): counter<=0, go to GAP, btn_out<=0.
  - btn_out is therefore high for exactly HOLD cycles.
- GAP:
  - btn_out=0, busy=1, req_ready=0.
  - When counter == GAP_TICKS-1: go to IDLE, done<=1 for one cycle, busy<=0.
  - req_ready is high in the same cycle done is high.
- Back-to-back requests: a request held during the done cycle is accepted in that cycle. Minimum request-to-request period is HOLD+GAP_TICKS+1 cycles.
- Handshake rules:
  - req_valid while not ready is ignored, not stored. The requester must hold it.
  - req_long is a don't-care outside the handshake cycle.
- Counter: 8 bits, never wraps. Terminal compare is equality; no state is reachable with counter > 255.
- Reset mid-PRESS: btn_out drops to 0 asynchronously; the in-flight request is discarded with no done pulse.
- Parameters out of range: elaboration error (generate-time check). No runtime clamping.
- Outputs btn_out, busy, done are registered. req_ready is decoded from state only and has no combinational path from req_valid.

Optional Feature:
- Macro PRESS_GEN_QUEUE_EN.
- Defined:
  - Adds a one-entry pending slot (valid bit + type bit).
  - req_ready = (state==IDLE) || !pending_valid.
  - A request accepted during PRESS/GAP is stored. On GAP exit, the FSM goes straight to PRESS with the stored type, counter<=0, pending cleared; done still pulses.
  - btn_out low time between the two presses is exactly GAP_TICKS.
  - Reset clears the pending slot.
- Undefined: behaviour exactly as above; no pending storage.

Decomposition:
- Shared package calc_btn_pkg:
  - FSM state encoding (IDLE=2'd0, PRESS=2'd1, GAP=2'd2).
  - Default tick constants.
  - DETECT_THRESHOLD=100, used in the LONG_TICKS range check.
- Sub-module tick_counter: 8-bit clear/enable counter with terminal-count compare output. Reused for PRESS and GAP with a muxed terminal value.

Test Plan:
1. Reset release, req_valid=1, req_long=0 at cycle 5 -> btn_out high cycles 6..15 (10 cycles), low 16..20, done=1 at cycle 21 with req_ready=1. Chained detector emits short_press once.
2. req_long=1 -> btn_out high exactly 150 cycles. Detector emits long_press once while high and no short_press on release.
3. req_valid held continuously with alternating type -> new btn_out rise exactly 1 cycle after each done. Period is SHORT 16 / LONG 156 cycles.
4. rst_n low at PRESS tick 40 of a long request -> btn_out=0 immediately (async), no done; after release, req_ready=1 and the next short request yields a 10-cycle pulse.
5. req_valid pulsed for 1 cycle during GAP (queue off) -> ignored; btn_out stays low and no second press occurs.
6. PRESS_GEN_QUEUE_EN: second (long) request during first PRESS -> req_ready drops after acceptance. btn_out low exactly 5 cycles between pulses; second pulse is 150 cycles; two done pulses in total.

Source files
------------

// File: rtl/calc_btn_pkg.sv
// Shared types and constants for the S2 button waveform generator.
package calc_btn_pkg;

    localparam int unsigned CNT_W = 8;

    localparam int unsigned DEF_SHORT_TICKS = 10;
    localparam int unsigned DEF_LONG_TICKS  = 150;
    localparam int unsigned DEF_GAP_TICKS   = 5;

    // Long presses must outlast the detector threshold plus edge latency.
    localparam int unsigned DETECT_THRESHOLD = 100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/press_waveform_gen_tick_counter.sv
// Clear/enable tick counter with an equality terminal-count flag.
module tick_counter
    import calc_btn_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/press_waveform_gen.sv
// Button press waveform generator (short/long press then a low gap).
// Define PRESS_GEN_QUEUE_EN to add a one-entry pending request slot.
module press_waveform_gen
    import calc_btn_pkg::*;
#(
    parameter int unsigned SHORT_TICKS = DEF_SHORT_TICKS,
    parameter int unsigned LONG_TICKS  = DEF_LONG_TICKS,
    parameter int unsigned GAP_TICKS   = DEF_GAP_TICKS
) (
    input  logic clk_db,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_long,
    output logic req_ready,
    output logic btn_out,
    output logic busy,
    output logic done
);

    if (SHORT_TICKS < 1 || SHORT_TICKS > 99) begin : g_bad_short
        $error("SHORT_TICKS out of range 1..99");
    end
    if (LONG_TICKS < DETECT_THRESHOLD + 2 || LONG_TICKS > 255) begin : g_bad_long
        $error("LONG_TICKS out of range 102..255");
    end
    if (GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_bad_gap
        $error("GAP_TICKS out of range 1..255");
    end

    localparam logic [CNT_W-1:0] SHORT_TERM = CNT_W'(SHORT_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_TERM  = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_TERM   = CNT_W'(GAP_TICKS - 1);

    state_t           state;
    state_t           state_n;
    logic             long_q;
    logic             long_n;
    logic             done_n;
    logic             cnt_clr;
    logic             cnt_en;
    logic             at_term;
    logic [CNT_W-1:0] term;
    logic             hs;

`ifdef PRESS_GEN_QUEUE_EN
    logic pend_v;
    logic pend_l;
    logic pend_v_n;
    logic pend_l_n;

    assign req_ready = (state == IDLE) || !pend_v;
`else
    assign req_ready = (state == IDLE);
`endif

    assign hs = req_valid && req_ready;

    assign term = (state == GAP) ? GAP_TERM :
                  (long_q ? LONG_TERM : SHORT_TERM);

    tick_counter u_cnt (
        .clk     (clk_db),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .term    (term),
        .at_term (at_term)
    );

    always_comb begin
        state_n = state;
        long_n  = long_q;
        done_n  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
`ifdef PRESS_GEN_QUEUE_EN
        pend_v_n = pend_v;
        pend_l_n = pend_l;
`endif
        unique case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (hs) begin
                    state_n = PRESS;
                    long_n  = req_long;
                end
            end
            PRESS: begin
                if (at_term) begin
                    cnt_clr = 1'b1;
                    state_n = GAP;
                end else begin
                    cnt_en = 1'b1;
                end
`ifdef PRESS_GEN_QUEUE_EN
                if (hs) begin
                    pend_v_n = 1'b1;
                    pend_l_n = req_long;
                end
`endif
            end
            GAP: begin
                if (at_term) begin
                    cnt_clr = 1'b1;
                    done_n  = 1'b1;
                    state_n = IDLE;
`ifdef PRESS_GEN_QUEUE_EN
                    // Chain straight into the next press so the low
                    // time stays exactly one gap.
                    if (pend_v) begin
                        state_n  = PRESS;
                        long_n   = pend_l;
                        pend_v_n = 1'b0;
                    end else if (hs) begin
                        state_n = PRESS;
                        long_n  = req_long;
                    end
`endif
                end else begin
                    cnt_en = 1'b1;
`ifdef PRESS_GEN_QUEUE_EN
                    if (hs) begin
                        pend_v_n = 1'b1;
                        pend_l_n = req_long;
                    end
`endif
                end
            end
            default: begin
                cnt_clr = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_db or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_db or negedge rst_n) begin
        if (!rst_n) begin
            long_q  <= 1'b0;
            btn_out <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            long_q  <= long_n;
            btn_out <= (state_n == PRESS);
            busy    <= (state_n != IDLE);
            done    <= done_n;
        end
    end

`ifdef PRESS_GEN_QUEUE_EN
    always_ff @(posedge clk_db or negedge rst_n) begin
        if (!rst_n) begin
            pend_v <= 1'b0;
            pend_l <= 1'b0;
        end else begin
            pend_v <= pend_v_n;
            pend_l <= pend_l_n;
        end
    end
`endif

endmodule

// File: tb/tb_press_waveform_gen.sv
// Self-checking bench for press_waveform_gen.
module tb_press_waveform_gen;

    localparam int SH = 10;
    localparam int LG = 150;
    localparam int GP = 5;

    localparam logic [3:0] O_IDLE = 4'b0001;
    localparam logic [3:0] O_PRS  = 4'b1100;
    localparam logic [3:0] O_GAP  = 4'b0100;
    localparam logic [3:0] O_DON  = 4'b0011;

    logic clk_db = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0;
    logic req_long = 1'b0;
    logic req_ready;
    logic btn_out;
    logic busy;
    logic done;

    int total = 0;
    int bad = 0;

    press_waveform_gen #(
        .SHORT_TICKS (SH),
        .LONG_TICKS  (LG),
        .GAP_TICKS   (GP)
    ) dut (
        .clk_db    (clk_db),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_long  (req_long),
        .req_ready (req_ready),
        .btn_out   (btn_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_db = ~clk_db;

    typedef struct {
        logic       v;
        logic       l;
        int         n;
        logic [3:0] e;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [3:0] outs();
        return {btn_out, busy, done, req_ready};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout", name);
    endtask

    task automatic step();
        @(negedge clk_db);
    endtask

    task automatic add(input logic v, input logic l, input int n,
                       input logic [3:0] e);
        vec_t r;
        r.v = v;
        r.l = l;
        r.n = n;
        r.e = e;
        tbl.push_back(r);
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_long = 1'b0;
        step();
        chk("rst_hold", int'({btn_out, busy, done}), 0);
        rst_n = 1'b1;
        chk("rst_release", int'(outs()), int'(O_IDLE));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        req_valid = 1'b0;
        while ((busy || done) && k < 400) begin
            step();
            k++;
        end
        if (k >= 400) fail_now(name);
    endtask

`ifndef PRESS_GEN_QUEUE_EN
    task automatic run_table();
        foreach (tbl[i]) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                req_valid = tbl[i].v;
                req_long = tbl[i].l;
                chk($sformatf("tbl[%0d].%0d", i, j), int'(outs()),
                    int'(tbl[i].e));
                step();
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic run_chain();
        int cyc;
        int last_rise;
        int last_done;
        int nr;
        logic prev_b;
        cyc = 0;
        last_rise = -1;
        last_done = -1;
        nr = 0;
        prev_b = 1'b0;
        req_valid = 1'b1;
        req_long = 1'b0;
        while (nr < 5 && cyc < 2000) begin
            if (btn_out && !prev_b) begin
                if (last_done >= 0)
                    chk("chain_rise_after_done", cyc - last_done, 1);
                if (last_rise >= 0)
                    chk("chain_period", cyc - last_rise,
                        ((nr - 1) % 2 == 1) ? LG + GP + 1 : SH + GP + 1);
                last_rise = cyc;
                nr++;
            end
            if (done) begin
                last_done = cyc;
                req_long = ~req_long;
            end
            prev_b = btn_out;
            step();
            cyc++;
        end
        if (nr < 5) fail_now("chain_rises");
        drain("chain_drain");
    endtask

    task automatic run_mid_reset();
        int hi;
        int dn;
        req_valid = 1'b1;
        req_long = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (40) step();
        chk("mid_pre_btn", int'(btn_out), 1);
        #2 rst_n = 1'b0;
        #1 chk("mid_async", int'({btn_out, busy, done}), 0);
        step();
        step();
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            chk("mid_after", int'(outs()), int'(O_IDLE));
            step();
        end
        req_valid = 1'b1;
        req_long = 1'b0;
        step();
        req_valid = 1'b0;
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            hi += int'(btn_out);
            dn += int'(done);
            step();
        end
        chk("mid_short_len", hi, SH);
        chk("mid_done_cnt", dn, 1);
    endtask

    task automatic run_random();
        int m_start;
        int m_hold;
        logic eb;
        logic ebz;
        logic ed;
        m_start = -10000;
        m_hold = SH;
        for (int k = 0; k < 4000; k++) begin
            eb = (k >= m_start) && (k < m_start + m_hold);
            ebz = (k >= m_start) && (k < m_start + m_hold + GP);
            ed = (k == m_start + m_hold + GP);
            chk($sformatf("rand@%0d", k), int'(outs()),
                int'({eb, ebz, ed, !ebz}));
            req_valid = ($urandom_range(0, 7) == 0);
            req_long = ($urandom_range(0, 3) == 0);
            if (req_valid && !ebz) begin
                m_start = k + 1;
                m_hold = req_long ? LG : SH;
            end
            step();
        end
        drain("rand_drain");
    endtask
`else
    task automatic run_queue();
        logic bt[200];
        logic dn[200];
        int i;
        int h1;
        int l1;
        int h2;
        int dc;
        req_valid = 1'b1;
        req_long = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("q_ready_pre", int'(req_ready), 1);
        req_valid = 1'b1;
        req_long = 1'b1;
        step();
        req_valid = 1'b0;
        req_long = 1'b0;
        chk("q_ready_drop", int'(req_ready), 0);
        for (int k = 0; k < 200; k++) begin
            bt[k] = btn_out;
            dn[k] = done;
            step();
        end
        i = 0;
        h1 = 0;
        l1 = 0;
        h2 = 0;
        dc = 0;
        while (i < 200 && bt[i]) begin h1++; i++; end
        while (i < 200 && !bt[i]) begin l1++; i++; end
        while (i < 200 && bt[i]) begin h2++; i++; end
        for (int k = 0; k < 200; k++) dc += int'(dn[k]);
        chk("q_first_rest", h1, SH - 3);
        chk("q_gap_low", l1, GP);
        chk("q_second_len", h2, LG);
        chk("q_done_cnt", dc, 2);
        drain("q_drain");
    endtask
`endif

    initial begin
        do_reset();
`ifndef PRESS_GEN_QUEUE_EN
        add(0, 0, 5, O_IDLE);
        add(1, 0, 1, O_IDLE);
        add(0, 0, SH, O_PRS);
        add(0, 0, GP, O_GAP);
        add(0, 0, 1, O_DON);
        add(0, 0, 3, O_IDLE);
        add(1, 1, 1, O_IDLE);
        add(0, 0, LG, O_PRS);
        add(0, 0, GP, O_GAP);
        add(0, 0, 1, O_DON);
        add(0, 0, 2, O_IDLE);
        add(1, 0, 1, O_IDLE);
        add(1, 1, 2, O_PRS);
        add(0, 0, SH - 2, O_PRS);
        add(0, 0, 2, O_GAP);
        add(1, 1, 1, O_GAP);
        add(0, 0, 2, O_GAP);
        add(0, 0, 1, O_DON);
        add(0, 0, 5, O_IDLE);
        add(1, 0, 1, O_IDLE);
        add(0, 0, SH, O_PRS);
        add(0, 0, GP, O_GAP);
        add(1, 0, 1, O_DON);
        add(0, 0, SH, O_PRS);
        add(0, 0, GP, O_GAP);
        add(0, 0, 1, O_DON);
        add(0, 0, 1, O_IDLE);
        run_table();
        run_chain();
        run_mid_reset();
        drain("mid_drain");
        do_reset();
        run_random();
`else
        run_queue();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
